// File: rtl/param_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_register
// Purpose  : WIDTH-bit shift/rotate register with parallel load and a counted
//            multi-shift sequence reporting completion via busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_MODE_SRL = 3'b000;
    localparam logic [2:0] c_MODE_SRA = 3'b001;
    localparam logic [2:0] c_MODE_SLL = 3'b010;
    localparam logic [2:0] c_MODE_ROR = 3'b011;
    localparam logic [2:0] c_MODE_ROL = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_mode;
    logic [CNT_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_q;
    logic               r_shift_out;
    logic               r_done;

    logic [2:0]         w_mode_sel;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_shifted_out;
    logic               w_mode_valid;
    logic               w_do_load;
    logic               w_do_shift;
    logic               w_latch;
    logic               w_done_next;

    // A running sequence uses the mode captured at start, not the live input.
    assign w_mode_sel = (r_state == ST_SHIFT) ? r_mode : mode;

    always_comb begin
        w_shifted     = r_q;
        w_shifted_out = r_shift_out;
        w_mode_valid  = 1'b1;
        case (w_mode_sel)
            c_MODE_SRL: begin
                w_shifted     = {serial_in, r_q[WIDTH-1:1]};
                w_shifted_out = r_q[0];
            end
            c_MODE_SRA: begin
                w_shifted     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_shifted_out = r_q[0];
            end
            c_MODE_SLL: begin
                w_shifted     = {r_q[WIDTH-2:0], serial_in};
                w_shifted_out = r_q[WIDTH-1];
            end
            c_MODE_ROR: begin
                w_shifted     = {r_q[0], r_q[WIDTH-1:1]};
                w_shifted_out = r_q[0];
            end
            c_MODE_ROL: begin
                w_shifted     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_shifted_out = r_q[WIDTH-1];
            end
            default: w_mode_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_do_shift   = 1'b0;
        w_latch      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_do_load = 1'b1;
                end else if (start) begin
                    if (count != '0) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else if (shift) begin
                    w_do_shift = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (load) begin
                    // Abort: no completion pulse for a cancelled sequence.
                    w_do_load    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_do_shift = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            r_shift_out <= 1'b0;
            r_done      <= 1'b0;
            r_mode      <= c_MODE_SRL;
            r_remaining <= '0;
        end else begin
            r_done <= w_done_next;
            if (w_do_load) begin
                r_q <= data_in;
            end else if (w_do_shift && w_mode_valid) begin
                r_q         <= w_shifted;
                r_shift_out <= w_shifted_out;
            end
            // Reserved modes still consume a step so the sequence length is exact.
            if (w_latch) begin
                r_mode      <= mode;
                r_remaining <= count;
            end else if (r_state == ST_SHIFT) begin
                r_remaining <= w_do_load ? '0 : (r_remaining - CNT_W'(1));
            end
        end
    end

    assign q         = r_q;
    assign shift_out = r_shift_out;
    assign busy      = (r_state == ST_SHIFT);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_register
// Purpose  : Scoreboard-driven bench for param_shift_register (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [2:0]       mode;
    logic             serial_in;
    logic             shift;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             shift_out;
    logic             busy;
    logic             done;

    param_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .mode(mode),
        .serial_in(serial_in), .shift(shift), .start(start), .count(count),
        .q(q), .shift_out(shift_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] v;   // {q, shift_out, busy, done}
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_q;
    logic       m_so;

    // Reference shifter: returns {shift_out, q}.
    function automatic logic [8:0] ref_shift(input logic [2:0] md, input logic [7:0] b,
                                             input logic sin, input logic so);
        case (md)
            3'd0:    return {b[0], (b >> 1) | {sin, 7'b0}};
            3'd1:    return {b[0], 8'($signed(b) >>> 1)};
            3'd2:    return {b[7], (b << 1) | {7'b0, sin}};
            3'd3:    return {b[0], (b >> 1) | (b << 7)};
            3'd4:    return {b[7], (b << 1) | (b >> 7)};
            default: return {so, b};
        endcase
    endfunction

    task automatic push_exp(input string nm, input logic [7:0] eq, input logic eso,
                            input logic eb, input logic ed);
        exp_t x;
        x.name = nm;
        x.v    = {eq, eso, eb, ed};
        sb.push_back(x);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        load = 0; start = 0; shift = 0; serial_in = 0; mode = 0; count = 0; data_in = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_q = 0; m_so = 0;
        push_exp("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, shift_out, busy, done} !== e.v) begin
            errors++;
            $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
        end
        rst = 0;
    endtask

    task automatic test_legacy;
        for (int i = 0; i < 9; i++) begin
            load = (i == 0); data_in = 8'hB5; shift = (i != 0); mode = 3'd0; serial_in = 0;
            if (i == 0) m_q = 8'hB5;
            else {m_so, m_q} = ref_shift(3'd0, m_q, 1'b0, m_so);
            push_exp($sformatf("legacy_step%0d", i), m_q, m_so, 1'b0, 1'b0);
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
            if (i == 1) begin
                checks++;
                if (q !== 8'h5A || shift_out !== 1'b1) begin
                    errors++;
                    $display("FAIL legacy_first: got q=%h so=%b required q=5a so=1", q, shift_out);
                end
            end
        end
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL legacy_flush: got q=%h required q=00", q);
        end
        idle_inputs();
    endtask

    task automatic test_sra;
        for (int i = 0; i < 6; i++) begin
            load = (i == 0); data_in = 8'h96; start = (i == 1); count = 4'd3; mode = 3'd1;
            if (i == 0) m_q = 8'h96;
            else if (i >= 2 && i <= 4) {m_so, m_q} = ref_shift(3'd1, m_q, 1'b0, m_so);
            push_exp($sformatf("sra_step%0d", i), m_q, m_so, (i >= 1 && i <= 3), (i == 4));
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
            if (i == 4) begin
                checks++;
                if (q !== 8'hF2 || shift_out !== 1'b1 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL sra_final: got q=%h so=%b done=%b required q=f2 so=1 done=1",
                             q, shift_out, done);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_rol;
        for (int i = 0; i < 7; i++) begin
            load = (i == 0); data_in = 8'h81; start = (i == 1); count = 4'd4;
            mode = (i >= 2) ? 3'($urandom_range(0, 7)) : 3'd4;
            if (i == 0) m_q = 8'h81;
            else if (i >= 2 && i <= 5) {m_so, m_q} = ref_shift(3'd4, m_q, 1'b0, m_so);
            push_exp($sformatf("rol_step%0d", i), m_q, m_so, (i >= 1 && i <= 4), (i == 5));
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
            if (i == 5) begin
                checks++;
                if (q !== 8'h18 || shift_out !== 1'b0) begin
                    errors++;
                    $display("FAIL rol_final: got q=%h so=%b required q=18 so=0", q, shift_out);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero_count;
        for (int i = 0; i < 4; i++) begin
            start = (i <= 1); count = (i == 0) ? 4'd0 : 4'd1; mode = 3'd0; serial_in = 1'b1;
            if (i == 2) {m_so, m_q} = ref_shift(3'd0, m_q, 1'b1, m_so);
            push_exp($sformatf("zero_step%0d", i), m_q, m_so, (i == 1), (i == 0 || i == 2));
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_abort;
        for (int i = 0; i < 6; i++) begin
            load = (i == 0 || i == 3); data_in = (i == 0) ? 8'h01 : 8'hAA;
            start = (i == 1 || i == 2); count = (i == 1) ? 4'd5 : 4'd1;
            mode = (i == 1) ? 3'd2 : 3'd0; serial_in = 0;
            if (i == 0) m_q = 8'h01;
            else if (i == 2) {m_so, m_q} = ref_shift(3'd2, m_q, 1'b0, m_so);
            else if (i == 3) m_q = 8'hAA;
            push_exp($sformatf("abort_step%0d", i), m_q, m_so, (i == 1 || i == 2), 1'b0);
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reserved_and_long;
        // Reserved single shift and reserved counted pair hold q/shift_out; then SRL x15.
        for (int i = 0; i < 23; i++) begin
            load = (i == 0 || i == 5); data_in = (i == 0) ? 8'hC3 : 8'hFF;
            shift = (i == 1); start = (i == 2 || i == 6);
            count = (i == 2) ? 4'd2 : 4'd15;
            mode = (i <= 4) ? 3'd5 + 3'(i % 2) : 3'd0; serial_in = 0;
            if (i == 0) m_q = 8'hC3;
            else if (i == 5) m_q = 8'hFF;
            else if (i >= 7 && i <= 21) {m_so, m_q} = ref_shift(3'd0, m_q, 1'b0, m_so);
            push_exp($sformatf("resv_long_step%0d", i), m_q, m_so,
                     (i == 2 || i == 3 || (i >= 6 && i <= 20)), (i == 4 || i == 21));
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
        end
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL long_count_zero: got q=%h required q=00", q);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) begin
            load = (i == 0); data_in = 8'h55; start = (i == 1); count = 4'd6; mode = 3'd0;
            cyc();
        end
        #2 rst = 1;
        #1;
        push_exp("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, shift_out, busy, done} !== e.v) begin
            errors++;
            $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
        end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        m_q = 0; m_so = 0;
        for (int i = 0; i < 8; i++) begin
            load = (i == 0); data_in = 8'h3C;
            if (i == 0) m_q = 8'h3C;
            push_exp($sformatf("post_reset_step%0d", i), m_q, m_so, 1'b0, 1'b0);
            cyc();
            e = sb.pop_front(); checks++;
            if ({q, shift_out, busy, done} !== e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", e.name, {q, shift_out, busy, done}, e.v);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_sra();
        test_rol();
        test_zero_count();
        test_abort();
        test_reserved_and_long();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_shift_register.md
# param_shift_register

Parametrised successor to the multiplier-operand shift register: a WIDTH-bit register with parallel load, five shift/rotate modes and a serial fill bit. It supports single-step shifting and a counted multi-shift sequence with a busy/done handshake. It sits in the shift-add datapath, where it holds the multiplier or the partial-product word, and gives the controller a completion pulse instead of requiring an external shift counter.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the shift-count input; a sequence performs up to 2^CNT_W−1 shifts
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  parallel load of data_in; highest priority
- data_in  input  WIDTH  parallel load value
- mode  input  3  shift operation: 000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL, 101–111 reserved (hold)
- serial_in  input  1  fill bit: MSB for SRL, LSB for SLL; ignored by SRA and rotates
- shift  input  1  single shift this cycle (idle only)
- start  input  1  begin counted sequence of `count` shifts (idle only)
- count  input  CNT_W  number of shifts for the sequence
- q  output  WIDTH  register contents
- shift_out  output  1  bit that left the register on the most recent shift
- busy  output  1  counted sequence in progress
- done  output  1  one-cycle pulse: sequence complete

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1. Holds latched mode and remaining-count (CNT_W bits).
- IDLE priority is load > start > shift.
  - load: q←data_in, stay IDLE.
  - start with count≠0: latch mode, remaining←count, go to SHIFT. q is unchanged on this edge.
  - start with count=0: q unchanged, done=1 next cycle, stay IDLE.
  - shift: one shift using the live mode and serial_in.
- SHIFT:
  - Each edge performs one shift using the latched mode and the live serial_in, then remaining decrements.
  - On the shift where remaining=1, go to IDLE and set done=1 for exactly one cycle.
  - load while in SHIFT aborts: q←data_in, go to IDLE, no done pulse.
  - start and shift are ignored while busy.
- Shift definitions, with b = q before the edge:
  - SRL: {serial_in, b[W−1:1]}; shift_out=b[0]
  - SRA: {b[W−1], b[W−1:1]}; shift_out=b[0]
  - SLL: {b[W−2:0], serial_in}; shift_out=b[W−1]
  - ROR: {b[0], b[W−1:1]}; shift_out=b[0]
  - ROL: {b[W−2:0], b[W−1]}; shift_out=b[W−1]
  - Reserved modes: q and shift_out unchanged, but a counted step is still consumed.
- shift_out holds its value between shifts and updates only on a performed shift.
- A count ≥ WIDTH is legal; shifting simply continues (SRL with serial_in=0 yields 0).
- With mode=000, serial_in=0 and shift tied high, the block reproduces the legacy load/shift-right behaviour.

## Timing
- Reset (asynchronous, immediate, any state): q=0, shift_out=0, busy=0, done=0, state=IDLE, remaining=0. An in-flight sequence is dropped with no done pulse.
- Load: q shows data_in the cycle after the load edge. Single shift: one-cycle latency.
- Counted sequence: start is sampled at edge E0 and shifts occur at E1..En.
  - busy is high from after E0 until after En (n cycles).
  - done is high for the single cycle after En, when q already holds the final value.
  - Total latency from start to done is n+1 edges.
- count=0: done is high for the cycle after E0; busy never rises.
- done and busy are never high together.
- A new start is accepted in the same cycle done is high, since the state is already IDLE.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Legacy mode, WIDTH=8: load 0xB5, then one shift with mode 000 and serial_in=0 → q=0x5A, shift_out=1. Hold shift high 7 more cycles → q=0x00.
- SRA sequence: load 0x96, start with count=3, mode 001 → q goes 0xCB, 0xE5, 0xF2. busy is high for 3 cycles, then done pulses for 1 cycle with q=0xF2 and shift_out=1.
- ROL sequence: load 0x81, start with count=4, mode 100 → q=0x18 at done, shift_out=0. Toggling mode mid-sequence has no effect on the result.
- Zero count: start with count=0 → done=1 for one cycle, busy stays 0, q unchanged. Then start with count=1 on the done cycle → accepted, done again 2 cycles later.
- Abort: load 0x01, start SLL count=5. On the 2nd busy cycle assert load with 0xAA → q=0xAA, busy=0, no done. A start asserted while busy is ignored.
- Async reset mid-sequence: assert rst between edges → q=0, busy=0, done=0, shift_out=0 immediately. After release, the block is idle and a new load works.
